// File: rtl/lsu_bus_master.sv
// Load/store engine: issues one req/ack data-bus transfer per memory op and stalls the core until it ends.
// Latency: accept cycle, then REQ until ack (or timeout), then a one-cycle DONE; misaligned ops skip REQ.
// Backpressure: stall holds the core while the op is accepted and in REQ; the bus throttles via busAck.
module lsu_bus_master #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic        en,
  input  logic [5:0]  cuOP,
  input  logic [31:0] addr,
  input  logic [31:0] storeData,
  input  logic        busAck,
  input  logic [31:0] busRdata,
  output logic        busReq,
  output logic        busWen,
  output logic [31:0] busAddr,
  output logic [3:0]  busBe,
  output logic [31:0] busWdata,
  output logic [31:0] memload,
  output logic        stall,
  output logic        done,
  output logic        misaligned,
  output logic        timeout
);

  localparam logic [5:0] OP_LB  = 6'd10;
  localparam logic [5:0] OP_LH  = 6'd11;
  localparam logic [5:0] OP_LW  = 6'd12;
  localparam logic [5:0] OP_LBU = 6'd13;
  localparam logic [5:0] OP_LHU = 6'd14;
  localparam logic [5:0] OP_SB  = 6'd15;
  localparam logic [5:0] OP_SH  = 6'd16;
  localparam logic [5:0] OP_SW  = 6'd17;

  localparam logic [CNT_W-1:0] LP_TO    = CNT_W'(TIMEOUT_CYCLES);
  localparam bit               LP_TO_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [5:0]         r_op;
  logic [31:0]        r_addr;
  logic [31:0]        r_sdata;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_mis;
  logic               r_to;
  logic [31:0]        r_memload;

  logic               w_mem_op;
  logic               w_misal;
  logic               w_accept;
  logic               w_ack_ok;
  logic               w_to_hit;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic               w_is_store;
  logic [31:0]        w_load_val;

  assign w_mem_op   = (cuOP >= OP_LB) && (cuOP <= OP_SW);
  assign w_cnt_inc  = r_cnt + 1'b1;
  assign w_is_store = (r_op == OP_SB) || (r_op == OP_SH) || (r_op == OP_SW);

  // Alignment check on the incoming op; byte ops can never be misaligned.
  always_comb begin
    w_misal = 1'b0;
    case (cuOP)
      OP_LH, OP_LHU, OP_SH: w_misal = addr[0];
      OP_LW, OP_SW:         w_misal = |addr[1:0];
      default:              w_misal = 1'b0;
    endcase
  end

  // Next-state logic: accept in IDLE, wait for ack or timeout in REQ, single DONE cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_ack_ok    = 1'b0;
    w_to_hit    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (en && w_mem_op) begin
          w_accept    = 1'b1;
          w_state_nxt = w_misal ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        // An ack landing on the final allowed cycle still counts as success.
        if (busAck) begin
          w_ack_ok    = 1'b1;
          w_state_nxt = S_DONE;
        end else if (LP_TO_EN && (w_cnt_inc == LP_TO)) begin
          w_to_hit    = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Latch the op on accept, run the REQ timeout counter, record completion flags.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_op    <= '0;
      r_addr  <= '0;
      r_sdata <= '0;
      r_cnt   <= '0;
      r_mis   <= 1'b0;
      r_to    <= 1'b0;
    end else if (w_accept) begin
      r_op    <= cuOP;
      r_addr  <= addr;
      r_sdata <= storeData;
      r_cnt   <= '0;
      r_mis   <= w_misal;
      r_to    <= 1'b0;
    end else if (r_state == S_REQ && !busAck) begin
      r_cnt <= w_cnt_inc;
      if (w_to_hit) r_to <= 1'b1;
    end
  end

  // Select the addressed byte/half from the read word, right-justified.
  always_comb begin
    w_load_val = busRdata;
    case (r_op)
      OP_LB, OP_LBU: w_load_val = {24'b0, busRdata[{r_addr[1:0], 3'b000} +: 8]};
      OP_LH, OP_LHU: w_load_val = {16'b0, busRdata[{r_addr[1], 4'b0000} +: 16]};
      default:       w_load_val = busRdata;
    endcase
  end

  // memload only changes on a successful load ack.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst)                        r_memload <= '0;
    else if (w_ack_ok && !w_is_store) r_memload <= w_load_val;
  end

  // Bus byte enables and lane-replicated write data from the latched op.
  always_comb begin
    busBe    = 4'b0000;
    busWdata = 32'h0;
    case (r_op)
      OP_SB: begin
        busBe    = 4'b0001 << r_addr[1:0];
        busWdata = {4{r_sdata[7:0]}};
      end
      OP_SH: begin
        busBe    = 4'b0011 << {r_addr[1], 1'b0};
        busWdata = {2{r_sdata[15:0]}};
      end
      OP_SW: begin
        busBe    = 4'b1111;
        busWdata = r_sdata;
      end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: busBe = 4'b1111;
      default: busBe = 4'b0000;
    endcase
  end

  assign busReq     = (r_state == S_REQ);
  assign busWen     = w_is_store;
  assign busAddr    = {r_addr[31:2], 2'b00};
  assign memload    = r_memload;
  assign done       = (r_state == S_DONE);
  assign misaligned = (r_state == S_DONE) && r_mis;
  assign timeout    = (r_state == S_DONE) && r_to;
  // Reset also releases the pipeline even if en is still high from the old instruction.
  assign stall      = nRst && (((r_state == S_IDLE) && en && w_mem_op) || (r_state == S_REQ));

endmodule

// File: tb/tb_lsu_bus_master.sv
module tb_lsu_bus_master;

  logic        clk;
  logic        nRst;
  logic        en;
  logic [5:0]  cuOP;
  logic [31:0] addr;
  logic [31:0] storeData;
  logic        busAck;
  logic [31:0] busRdata;
  logic        busReq;
  logic        busWen;
  logic [31:0] busAddr;
  logic [3:0]  busBe;
  logic [31:0] busWdata;
  logic [31:0] memload;
  logic        stall;
  logic        done;
  logic        misaligned;
  logic        timeout;

  int n_checks = 0;
  int n_fail   = 0;

  // results of the last access
  int          r_stall, r_req, r_done, r_mis, r_to, r_unstable;
  logic [31:0] r_baddr, r_wdata;
  logic [3:0]  r_be;
  logic        r_wen;

  lsu_bus_master #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .nRst(nRst), .en(en), .cuOP(cuOP), .addr(addr), .storeData(storeData),
    .busAck(busAck), .busRdata(busRdata), .busReq(busReq), .busWen(busWen),
    .busAddr(busAddr), .busBe(busBe), .busWdata(busWdata), .memload(memload),
    .stall(stall), .done(done), .misaligned(misaligned), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Present one op from IDLE and act as the bus; ack on REQ cycle index ack_at (-1 = never).
  task automatic do_access(input logic [5:0] op, input logic [31:0] a, input logic [31:0] sd,
                           input int ack_at, input logic [31:0] rd);
    bit finished = 0;
    r_stall = 0; r_req = 0; r_done = 0; r_mis = 0; r_to = 0; r_unstable = 0;
    r_baddr = '0; r_wdata = '0; r_be = '0; r_wen = 1'b0;
    en = 1'b1; cuOP = op; addr = a; storeData = sd; busRdata = rd; busAck = 1'b0;
    for (int c = 0; c < 40 && !finished; c++) begin
      #1;
      if (stall) r_stall++;
      if (misaligned) r_mis++;
      if (timeout) r_to++;
      if (busReq) begin
        if (r_req == 0) begin
          r_baddr = busAddr; r_be = busBe; r_wen = busWen; r_wdata = busWdata;
        end else if (busAddr !== r_baddr || busBe !== r_be || busWen !== r_wen || busWdata !== r_wdata) begin
          r_unstable++;
        end
        r_req++;
        if (ack_at == r_req - 1) busAck = 1'b1;
      end
      if (done) begin
        r_done++;
        en = 1'b0;
        finished = 1;
      end
      tick();
      busAck = 1'b0;
    end
  endtask

  task automatic test_reset();
    nRst = 1'b0; en = 1'b0; cuOP = 6'd0; addr = '0; storeData = '0; busAck = 1'b0; busRdata = '0;
    #12;
    n_checks++; if (busReq !== 1'b0) begin n_fail++; $display("FAIL rst_busReq got=%0h exp=0", busReq); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall got=%0h exp=0", stall); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done got=%0h exp=0", done); end
    n_checks++; if (memload !== 32'h0) begin n_fail++; $display("FAIL rst_memload got=%h exp=0", memload); end
    n_checks++; if (misaligned !== 1'b0 || timeout !== 1'b0) begin n_fail++; $display("FAIL rst_flags got=%0h%0h exp=00", misaligned, timeout); end
    nRst = 1'b1;
    tick();
  endtask

  task automatic test_sw();
    do_access(6'd17, 32'h100, 32'hDEADBEEF, 1, 32'h0);
    n_checks++; if (r_baddr !== 32'h100) begin n_fail++; $display("FAIL sw_addr got=%h exp=00000100", r_baddr); end
    n_checks++; if (r_be !== 4'b1111) begin n_fail++; $display("FAIL sw_be got=%b exp=1111", r_be); end
    n_checks++; if (r_wen !== 1'b1) begin n_fail++; $display("FAIL sw_wen got=%0h exp=1", r_wen); end
    n_checks++; if (r_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sw_wdata got=%h exp=deadbeef", r_wdata); end
    n_checks++; if (r_stall != 3) begin n_fail++; $display("FAIL sw_stall_cycles got=%0d exp=3", r_stall); end
    n_checks++; if (r_req != 2) begin n_fail++; $display("FAIL sw_req_cycles got=%0d exp=2", r_req); end
    n_checks++; if (r_done != 1) begin n_fail++; $display("FAIL sw_done got=%0d exp=1", r_done); end
    n_checks++; if (r_unstable != 0) begin n_fail++; $display("FAIL sw_bus_stable got=%0d exp=0", r_unstable); end
    n_checks++; if (memload !== 32'h0) begin n_fail++; $display("FAIL sw_memload got=%h exp=0", memload); end
    #1;
    n_checks++; if (done !== 1'b0 || busReq !== 1'b0) begin n_fail++; $display("FAIL sw_after got=%0h%0h exp=00", done, busReq); end
  endtask

  task automatic test_sub_word_store();
    do_access(6'd15, 32'h203, 32'h000000A5, 0, 32'h0);
    n_checks++; if (r_baddr !== 32'h200) begin n_fail++; $display("FAIL sb_addr got=%h exp=00000200", r_baddr); end
    n_checks++; if (r_be !== 4'b1000) begin n_fail++; $display("FAIL sb_be got=%b exp=1000", r_be); end
    n_checks++; if (r_wdata !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL sb_wdata got=%h exp=a5a5a5a5", r_wdata); end
    n_checks++; if (r_stall != 2) begin n_fail++; $display("FAIL sb_stall_cycles got=%0d exp=2", r_stall); end
    do_access(6'd16, 32'h202, 32'h00001234, 0, 32'h0);
    n_checks++; if (r_be !== 4'b1100) begin n_fail++; $display("FAIL sh_be got=%b exp=1100", r_be); end
    n_checks++; if (r_wdata !== 32'h12341234) begin n_fail++; $display("FAIL sh_wdata got=%h exp=12341234", r_wdata); end
    n_checks++; if (r_wen !== 1'b1) begin n_fail++; $display("FAIL sh_wen got=%0h exp=1", r_wen); end
  endtask

  task automatic test_loads();
    do_access(6'd10, 32'h301, 32'h0, 0, 32'h11228344);
    n_checks++; if (memload !== 32'h00000083) begin n_fail++; $display("FAIL lb_memload got=%h exp=00000083", memload); end
    n_checks++; if (r_be !== 4'b1111 || r_wen !== 1'b0 || r_wdata !== 32'h0) begin n_fail++; $display("FAIL lb_bus got=%b/%0h/%h exp=1111/0/0", r_be, r_wen, r_wdata); end
    n_checks++; if (r_baddr !== 32'h300) begin n_fail++; $display("FAIL lb_addr got=%h exp=00000300", r_baddr); end
    do_access(6'd11, 32'h302, 32'h0, 0, 32'h11228344);
    n_checks++; if (memload !== 32'h00001122) begin n_fail++; $display("FAIL lh_memload got=%h exp=00001122", memload); end
    do_access(6'd12, 32'h300, 32'h0, 0, 32'h11228344);
    n_checks++; if (memload !== 32'h11228344) begin n_fail++; $display("FAIL lw_memload got=%h exp=11228344", memload); end
    do_access(6'd13, 32'h303, 32'h0, 0, 32'h11228344);
    n_checks++; if (memload !== 32'h00000011) begin n_fail++; $display("FAIL lbu_memload got=%h exp=00000011", memload); end
    do_access(6'd14, 32'h300, 32'h0, 0, 32'h11228344);
    n_checks++; if (memload !== 32'h00008344) begin n_fail++; $display("FAIL lhu_memload got=%h exp=00008344", memload); end
  endtask

  task automatic test_misaligned();
    do_access(6'd12, 32'h102, 32'h0, 0, 32'hFFFFFFFF);
    n_checks++; if (r_req != 0) begin n_fail++; $display("FAIL mis_lw_req got=%0d exp=0", r_req); end
    n_checks++; if (r_done != 1 || r_mis != 1) begin n_fail++; $display("FAIL mis_lw_pulse got=%0d/%0d exp=1/1", r_done, r_mis); end
    n_checks++; if (r_stall != 1) begin n_fail++; $display("FAIL mis_lw_stall got=%0d exp=1", r_stall); end
    n_checks++; if (memload !== 32'h00008344) begin n_fail++; $display("FAIL mis_lw_memload got=%h exp=00008344", memload); end
    do_access(6'd16, 32'h101, 32'h5555, 0, 32'h0);
    n_checks++; if (r_req != 0 || r_done != 1 || r_mis != 1) begin n_fail++; $display("FAIL mis_sh got=%0d/%0d/%0d exp=0/1/1", r_req, r_done, r_mis); end
    do_access(6'd10, 32'h103, 32'h0, 0, 32'h44332211);
    n_checks++; if (r_mis != 0 || memload !== 32'h00000044) begin n_fail++; $display("FAIL lb_odd got=%0d/%h exp=0/00000044", r_mis, memload); end
  endtask

  task automatic test_timeout();
    do_access(6'd12, 32'h400, 32'h0, -1, 32'hCAFEF00D);
    n_checks++; if (r_req != 4) begin n_fail++; $display("FAIL to_req_cycles got=%0d exp=4", r_req); end
    n_checks++; if (r_done != 1 || r_to != 1) begin n_fail++; $display("FAIL to_pulse got=%0d/%0d exp=1/1", r_done, r_to); end
    n_checks++; if (r_stall != 5) begin n_fail++; $display("FAIL to_stall got=%0d exp=5", r_stall); end
    n_checks++; if (memload !== 32'h00000044) begin n_fail++; $display("FAIL to_memload got=%h exp=00000044", memload); end
    do_access(6'd12, 32'h400, 32'h0, 3, 32'hCAFEF00D);
    n_checks++; if (r_req != 4 || r_to != 0) begin n_fail++; $display("FAIL ack_last got=%0d/%0d exp=4/0", r_req, r_to); end
    n_checks++; if (memload !== 32'hCAFEF00D) begin n_fail++; $display("FAIL ack_last_memload got=%h exp=cafef00d", memload); end
  endtask

  task automatic test_reset_mid_req();
    en = 1'b1; cuOP = 6'd12; addr = 32'h500; busAck = 1'b0; busRdata = 32'h0;
    tick();
    n_checks++; if (busReq !== 1'b1) begin n_fail++; $display("FAIL mid_req_up got=%0h exp=1", busReq); end
    nRst = 1'b0;
    #1;
    n_checks++; if (busReq !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busReq got=%0h exp=0", busReq); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL mid_rst_stall got=%0h exp=0", stall); end
    n_checks++; if (memload !== 32'h0) begin n_fail++; $display("FAIL mid_rst_memload got=%h exp=0", memload); end
    en = 1'b0;
    tick();
    nRst = 1'b1;
    tick();
    do_access(6'd17, 32'h600, 32'h01020304, 0, 32'h0);
    n_checks++; if (r_done != 1 || r_req != 1 || r_to != 0) begin n_fail++; $display("FAIL post_rst_sw got=%0d/%0d/%0d exp=1/1/0", r_done, r_req, r_to); end
    n_checks++; if (r_wdata !== 32'h01020304 || r_baddr !== 32'h600) begin n_fail++; $display("FAIL post_rst_bus got=%h/%h exp=01020304/00000600", r_wdata, r_baddr); end
  endtask

  task automatic test_non_mem();
    int n_req = 0;
    int n_stall = 0;
    int n_done = 0;
    en = 1'b1; cuOP = 6'd28; addr = 32'h700;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (busReq) n_req++;
      if (stall) n_stall++;
      if (done) n_done++;
      tick();
    end
    en = 1'b0;
    n_checks++; if (n_stall != 0) begin n_fail++; $display("FAIL add_stall got=%0d exp=0", n_stall); end
    n_checks++; if (n_req != 0 || n_done != 0) begin n_fail++; $display("FAIL add_bus got=%0d/%0d exp=0/0", n_req, n_done); end
  endtask

  initial begin
    test_reset();
    test_sw();
    test_sub_word_store();
    test_loads();
    test_misaligned();
    test_timeout();
    test_reset_mid_req();
    test_non_mem();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
